// File: rtl/fpga_spi_cmd_regfile.sv
// SPI command receiver and configuration register file. It oversamples spck/mosi/ncs in the ck_1356meg domain.
// Fixed-length frames {cmd, payload} write registers or select a register for readback on miso during the next frame.
module fpga_spi_cmd_regfile #(
  parameter int CMD_W       = 4,
  parameter int DATA_W      = 12,
  parameter int NUM_REGS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          ck_1356meg,
  input  logic                          rst,
  input  logic                          spck,
  input  logic                          mosi,
  input  logic                          ncs,
  output logic                          miso,
  output logic [NUM_REGS*DATA_W-1:0]    regs_flat,
  output logic [NUM_REGS-1:0]           reg_upd,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int F     = CMD_W + DATA_W;
  localparam int CNT_W = $clog2(F + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(F);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(F + 1);
  localparam logic [CMD_W-1:0] CMD_READ = {CMD_W{1'b1}};

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_FRAME    = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic [SYNC_STAGES-1:0]       r_spck_sync;
  logic [SYNC_STAGES-1:0]       r_mosi_sync;
  logic [SYNC_STAGES-1:0]       r_ncs_sync;
  logic                         r_spck_prev;
  logic                         r_ncs_prev;

  logic [F-1:0]                 r_rx;
  logic [F-1:0]                 r_tx;
  logic [CNT_W-1:0]             r_cnt;
  logic [CMD_W-1:0]             r_sel;
  logic [NUM_REGS*DATA_W-1:0]   r_regs_flat;
  logic [NUM_REGS-1:0]          r_upd;
  logic                         r_ferr;
  logic                         r_busy;

  logic                         w_spck_s;
  logic                         w_mosi_s;
  logic                         w_ncs_s;
  logic                         w_spck_rise;
  logic                         w_spck_fall;
  logic                         w_ncs_rise;
  logic                         w_ncs_fall;
  logic                         w_in_frame;
  logic                         w_load;
  logic [DATA_W-1:0]            w_rb_val;
  logic [F-1:0]                 w_rb_word;
  logic [CMD_W-1:0]             w_cmd;
  logic [DATA_W-1:0]            w_payload;

  // Synchronisers for the asynchronous SPI pins, plus one history flop for edge detection
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      r_spck_sync <= '0;
      r_mosi_sync <= '0;
      r_ncs_sync  <= '0;
      r_spck_prev <= 1'b0;
      r_ncs_prev  <= 1'b0;
    end else begin
      r_spck_sync <= {r_spck_sync[SYNC_STAGES-2:0], spck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_spck_prev <= r_spck_sync[SYNC_STAGES-1];
      r_ncs_prev  <= r_ncs_sync[SYNC_STAGES-1];
    end
  end

  assign w_spck_s    = r_spck_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_spck_rise = w_spck_s & ~r_spck_prev;
  assign w_spck_fall = ~w_spck_s & r_spck_prev;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_prev;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_prev;

  // spck edges count only inside an armed frame; edges coincident with ncs transitions are dropped
  assign w_in_frame = (r_state == ST_FRAME) && !w_ncs_s;
  assign w_load     = w_ncs_fall && ((r_state == ST_IDLE) || (r_state == ST_COMMIT));

  assign w_cmd     = r_rx[F-1 -: CMD_W];
  assign w_payload = r_rx[DATA_W-1:0];

  // Readback value of the selected register; out-of-range selections read as zero
  always_comb begin
    w_rb_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_rb_val = (r_sel == CMD_W'(k)) ? r_regs_flat[k*DATA_W +: DATA_W] : w_rb_val;
    end
  end

  assign w_rb_word = {r_sel, w_rb_val};

  // State register
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      r_state <= ST_DISARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: disarmed until ncs is seen high, so a frame cut by reset is never committed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_DISARMED: begin
        if (w_ncs_s) w_state_nxt = ST_IDLE;
        else         w_state_nxt = ST_DISARMED;
      end
      ST_IDLE: begin
        if (w_ncs_fall) w_state_nxt = ST_FRAME;
        else            w_state_nxt = ST_IDLE;
      end
      ST_FRAME: begin
        if (w_ncs_rise) w_state_nxt = ST_COMMIT;
        else            w_state_nxt = ST_FRAME;
      end
      ST_COMMIT: begin
        if (w_ncs_fall) w_state_nxt = ST_FRAME;
        else            w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_DISARMED;
    endcase
  end

  // Shift registers and bit counter; miso is the tx MSB so it updates in the load cycle
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      r_rx   <= '0;
      r_tx   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_FRAME);
      if (w_load) begin
        r_rx  <= '0;
        r_cnt <= '0;
        r_tx  <= w_rb_word;
      end else if (w_in_frame && w_spck_rise) begin
        r_rx <= {r_rx[F-2:0], w_mosi_s};
        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
        else                  r_cnt <= r_cnt;
      end else if (w_in_frame && w_spck_fall) begin
        r_tx <= {r_tx[F-2:0], 1'b0};
      end else begin
        r_rx <= r_rx;
      end
    end
  end

  // Commit-cycle decode: the decode reads the shift register before any new-frame load clears it
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      r_regs_flat <= '0;
      r_upd       <= '0;
      r_ferr      <= 1'b0;
      r_sel       <= '0;
    end else begin
      r_upd  <= '0;
      r_ferr <= 1'b0;
      if (r_state == ST_COMMIT) begin
        if (r_cnt != CNT_FULL) begin
          r_ferr <= 1'b1;
        end else if (w_cmd == CMD_READ) begin
          r_sel <= w_payload[CMD_W-1:0];
        end else begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (w_cmd == CMD_W'(k + 1)) begin
              r_regs_flat[k*DATA_W +: DATA_W] <= w_payload;
              r_upd[k]                        <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign miso      = r_tx[F-1];
  assign regs_flat = r_regs_flat;
  assign reg_upd   = r_upd;
  assign frame_err = r_ferr;
  assign busy      = r_busy;

endmodule
